// File: rtl/palette_lookup_arbiter.sv
// Round-robin share of one combinational 16-entry palette among NUM_REQ sprite renderers.
// 1-cycle grant->response latency; rsp_ready low holds the response and blocks new grants.
module palette_lookup_arbiter #(
    parameter int         NUM_REQ         = 4,
    parameter int         ID_W            = $clog2(NUM_REQ),
    parameter logic [3:0] TRANSPARENT_IDX = 4'h0
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic                 flush,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [4*NUM_REQ-1:0] req_index,
    output logic [NUM_REQ-1:0]   req_grant,
    output logic [3:0]           pal_index,
    input  logic [11:0]          pal_rgb,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic [11:0]          rsp_rgb,
    output logic                 rsp_transparent
);

    typedef enum logic [1:0] {IDLE, SERVE, STALL} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] win;
    logic [ID_W-1:0] cand;
    logic [ID_W-1:0] sel;
    logic            found;
    logic            can_issue;
    logic            grant_any;

    assign rsp_valid = (state != IDLE);

    // STALL only blocks while rsp_ready is low; once it rises the slot frees in that same cycle.
    assign can_issue = Reset_n & ~flush & (~rsp_valid | rsp_ready);

    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    assign grant_any = can_issue & found;
    assign sel       = grant_any ? win : rr_ptr;
    assign pal_index = req_index[4*sel +: 4];

    always_comb begin
        req_grant = '0;
        if (grant_any) begin
            req_grant[win] = 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) state_nxt = SERVE;
                end
                SERVE, STALL: begin
                    if (!rsp_ready)     state_nxt = STALL;
                    else if (grant_any) state_nxt = SERVE;
                    else                state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rr_ptr          <= '0;
            rsp_id          <= '0;
            rsp_rgb         <= '0;
            rsp_transparent <= 1'b0;
        end else if (grant_any) begin
            rr_ptr          <= (win == ID_W'(NUM_REQ-1)) ? '0 : win + 1'b1;
            rsp_id          <= win;
            rsp_rgb         <= pal_rgb;
            rsp_transparent <= (pal_index == TRANSPARENT_IDX);
        end
    end

endmodule

// File: tb/tb_palette_lookup_arbiter.sv
// Bench for palette_lookup_arbiter: reference arbiter model feeds a response scoreboard, plus directed scenarios.
module tb_palette_lookup_arbiter;

    logic        Clk;
    logic        Reset_n;
    logic        flush;
    logic [3:0]  req_valid;
    logic [15:0] req_index;
    logic [3:0]  req_grant;
    logic [3:0]  pal_index;
    logic [11:0] pal_rgb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [11:0] rsp_rgb;
    logic        rsp_transparent;

    typedef struct {
        logic [1:0]  id;
        logic [11:0] rgb;
        logic        tr;
    } exp_t;

    exp_t        sb_q[$];
    logic [11:0] pal_mem [16];
    int          checks;
    int          errors;
    logic        mon_en;
    logic        m_valid;
    int          m_rr;

    palette_lookup_arbiter #(
        .NUM_REQ(4), .ID_W(2), .TRANSPARENT_IDX(4'h0)
    ) dut (
        .Clk(Clk), .Reset_n(Reset_n), .flush(flush),
        .req_valid(req_valid), .req_index(req_index), .req_grant(req_grant),
        .pal_index(pal_index), .pal_rgb(pal_rgb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_rgb(rsp_rgb), .rsp_transparent(rsp_transparent)
    );

    assign pal_rgb = pal_mem[pal_index];

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [3:0] v, input int ptr);
        for (int k = 0; k < 4; k++) begin
            if (v[(ptr + k) % 4]) return (ptr + k) % 4;
        end
        return -1;
    endfunction

    task automatic next_cycle();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        mon_en  = 1'b0;
        Reset_n = 1'b0;
        next_cycle();
        Reset_n = 1'b1;
        m_valid = 1'b0;
        m_rr    = 0;
        sb_q.delete();
        mon_en  = 1'b1;
    endtask

    // Reference model: expected grant each cycle, expected response queued on grant.
    always @(negedge Clk) begin
        if (mon_en) begin
            int         w;
            logic [3:0] eg;
            logic [3:0] eidx;
            exp_t       e;
            chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
            if (m_valid) begin
                if (sb_q.size() == 0) begin
                    chk("sb_underflow", 32'(sb_q.size()), 32'd1);
                end else begin
                    chk("rsp_id", 32'(rsp_id), 32'(sb_q[0].id));
                    chk("rsp_rgb", 32'(rsp_rgb), 32'(sb_q[0].rgb));
                    chk("rsp_transparent", 32'(rsp_transparent), 32'(sb_q[0].tr));
                end
            end
            w = -1;
            if (!flush && (!m_valid || rsp_ready)) w = pick(req_valid, m_rr);
            eg = (w >= 0) ? 4'(1 << w) : 4'b0000;
            chk("req_grant", 32'(req_grant), 32'(eg));
            e.id  = 2'd0;
            e.rgb = 12'd0;
            e.tr  = 1'b0;
            if (w >= 0) begin
                eidx  = req_index[4*w +: 4];
                chk("pal_index", 32'(pal_index), 32'(eidx));
                e.id  = 2'(w);
                e.rgb = pal_mem[eidx];
                e.tr  = (eidx == 4'h0);
            end
            if (flush) begin
                m_valid = 1'b0;
                sb_q.delete();
            end else begin
                if (m_valid && rsp_ready) begin
                    void'(sb_q.pop_front());
                    m_valid = 1'b0;
                end
                if (w >= 0) begin
                    sb_q.push_back(e);
                    m_valid = 1'b1;
                    m_rr    = (w + 1) % 4;
                end
            end
        end
    end

    initial begin
        checks    = 0;
        errors    = 0;
        mon_en    = 1'b0;
        m_valid   = 1'b0;
        m_rr      = 0;
        for (int i = 0; i < 16; i++) pal_mem[i] = 12'((i * 273) ^ 12'h5A3);
        pal_mem[0] = 12'hAEA;
        pal_mem[3] = 12'hB0B;
        pal_mem[4] = 12'hF76;
        Reset_n   = 1'b0;
        flush     = 1'b0;
        rsp_ready = 1'b1;
        req_valid = 4'b1111;
        req_index = 16'h5403;

        // Reset state, with requests present to prove grants are gated.
        repeat (2) next_cycle();
        @(negedge Clk);
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_id", 32'(rsp_id), 32'd0);
        chk("rst_rgb", 32'(rsp_rgb), 32'd0);
        chk("rst_tr", 32'(rsp_transparent), 32'd0);
        chk("rst_grant", 32'(req_grant), 32'd0);
        next_cycle();
        req_valid = 4'b0000;
        do_reset();

        // Single lookup of index 3.
        req_valid = 4'b0001;
        @(negedge Clk);
        chk("t1_grant", 32'(req_grant), 32'h1);
        next_cycle();
        req_valid = 4'b0000;
        @(negedge Clk);
        chk("t1_valid", 32'(rsp_valid), 32'd1);
        chk("t1_id", 32'(rsp_id), 32'd0);
        chk("t1_rgb", 32'(rsp_rgb), 32'hB0B);
        chk("t1_tr", 32'(rsp_transparent), 32'd0);
        repeat (2) next_cycle();

        // All requesters busy: grants rotate from requester 0.
        do_reset();
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            @(negedge Clk);
            chk("t2_grant", 32'(req_grant), 32'(1 << (k % 4)));
            if (k > 0) begin
                chk("t2_valid", 32'(rsp_valid), 32'd1);
                chk("t2_id", 32'(rsp_id), 32'((k - 1) % 4));
            end
            next_cycle();
        end

        // Downstream stall with requests pending.
        rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge Clk);
            chk("t3_grant_blocked", 32'(req_grant), 32'd0);
            chk("t3_valid_held", 32'(rsp_valid), 32'd1);
            next_cycle();
        end
        rsp_ready = 1'b1;
        @(negedge Clk);
        chk("t3_regrant", 32'(req_grant != 4'b0000), 32'd1);
        next_cycle();
        req_valid = 4'b0000;
        repeat (2) next_cycle();

        // Transparent index vs opaque index.
        req_valid = 4'b0001;
        req_index = 16'h5400;
        next_cycle();
        req_index = 16'h5404;
        @(negedge Clk);
        chk("t4_tr_set", 32'(rsp_transparent), 32'd1);
        chk("t4_rgb_aea", 32'(rsp_rgb), 32'hAEA);
        next_cycle();
        req_valid = 4'b0000;
        @(negedge Clk);
        chk("t4_tr_clr", 32'(rsp_transparent), 32'd0);
        chk("t4_rgb_f76", 32'(rsp_rgb), 32'hF76);
        next_cycle();

        // Pointer wrap: grant requester 1 so the pointer sits at 2.
        req_valid = 4'b0010;
        next_cycle();
        req_valid = 4'b0011;
        @(negedge Clk);
        chk("t5_wrap", 32'(req_grant), 32'h1);
        next_cycle();
        @(negedge Clk);
        chk("t5_next", 32'(req_grant), 32'h2);
        next_cycle();
        req_valid = 4'b0000;
        repeat (2) next_cycle();

        // Flush drops a held response.
        req_valid = 4'b0001;
        rsp_ready = 1'b0;
        next_cycle();
        flush = 1'b1;
        @(negedge Clk);
        chk("t6_flush_grant", 32'(req_grant), 32'd0);
        next_cycle();
        flush     = 1'b0;
        req_valid = 4'b0000;
        @(negedge Clk);
        chk("t6_flush_valid", 32'(rsp_valid), 32'd0);
        next_cycle();
        rsp_ready = 1'b1;

        // Asynchronous reset mid-stream.
        req_valid = 4'b1111;
        req_index = 16'h9876;
        repeat (3) next_cycle();
        #1;
        mon_en  = 1'b0;
        Reset_n = 1'b0;
        #1;
        chk("t6_arst_valid", 32'(rsp_valid), 32'd0);
        chk("t6_arst_id", 32'(rsp_id), 32'd0);
        chk("t6_arst_rgb", 32'(rsp_rgb), 32'd0);
        chk("t6_arst_tr", 32'(rsp_transparent), 32'd0);
        chk("t6_arst_grant", 32'(req_grant), 32'd0);
        next_cycle();
        req_valid = 4'b0000;
        do_reset();

        // Random traffic checked against the model.
        for (int k = 0; k < 400; k++) begin
            req_valid = 4'($urandom);
            req_index = 16'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            next_cycle();
        end
        req_valid = 4'b0000;
        flush     = 1'b0;
        rsp_ready = 1'b1;
        repeat (3) next_cycle();
        mon_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
